ram_burst_ctrl: RTL

- Request-side controller that sits directly upstream of the 64x8 single-port RAM.
- Accepts single or burst read/write commands over valid/ready handshakes.
- Sequences the RAM's write-enable, address and write-data pins one beat at a time.
- Returns read data on a back-pressurable response stream; the RAM never sees concurrent read and write.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_burst_ctrl_if.sv | 29 ++
 rtl/ram_addr_gen.sv | 52 +++++
 rtl/ram_burst_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the burst controller that fronts the 64x8 single-port RAM.
package ram_pkg;

   localparam int DW    = 8;
   localparam int AW    = 6;
   localparam int DEPTH = 2 ** AW;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ISSUE,
      RD_WAIT,
      RD_RESP
   } state_e;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [AW-1:0] len;
   } cmd_t;

   // Word addresses wrap modulo DEPTH with no error indication.
   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
      return AW'((int'(a) + 1) % DEPTH);
   endfunction

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-data and read-response streams between a requester and ram_burst_ctrl.
interface ram_burst_ctrl_if;
   import ram_pkg::*;

   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [AW-1:0] req_len;

   logic          wd_valid;
   logic          wd_ready;
   logic [DW-1:0] wd_data;

   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;

   modport master (
      output req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready,
      input  req_ready, wd_ready, rd_valid, rd_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_len, wd_valid, wd_data, rd_ready,
      output req_ready, wd_ready, rd_valid, rd_data
   );

endinterface

// File: rtl/ram_addr_gen.sv
// Burst address generator: start-address load, wrapping increment, beat counter and last-beat flag.
module ram_addr_gen
   import ram_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          advance,
   input  logic [AW-1:0] start_addr,
   input  logic [AW-1:0] len,
   output logic [AW-1:0] addr,
   output logic [AW-1:0] addr_next,
   output logic          last
);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] cnt_q,  cnt_d;
   logic [AW-1:0] len_q,  len_d;

   always_comb begin
      // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
      addr_d = addr_q;
      cnt_d  = cnt_q;
      len_d  = len_q;
      if (load) begin
         addr_d = start_addr;
         cnt_d  = '0;
         len_d  = len;
      end else if (advance) begin
         addr_d = addr_inc(addr_q);
         cnt_d  = cnt_q + AW'(1);
      end
   end

   // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         len_q  <= len_d;
      end
   end

   assign addr      = addr_q;
   assign addr_next = addr_inc(addr_q);
   assign last      = (cnt_q == len_q);

endmodule

// File: rtl/ram_burst_ctrl.sv
// Request-side burst controller for the 64x8 single-port RAM: one beat at a time, at most one read in flight.
module ram_burst_ctrl
   import ram_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   ram_burst_ctrl_if.slave bus,
   output logic            busy,
   output logic            ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [DW-1:0]   ram_wdata,
   input  logic [DW-1:0]   ram_rdata
);

   localparam int             WCW       = 2;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_LAT - 1);

   state_e         state_q,     state_d;
   logic           ram_we_q,    ram_we_d;
   logic [AW-1:0]  ram_addr_q,  ram_addr_d;
   logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
   logic [DW-1:0]  rd_data_q,   rd_data_d;
   logic [WCW-1:0] wait_q,      wait_d;

   cmd_t          req_cmd;
   logic          ag_load, ag_advance, ag_last;
   logic [AW-1:0] ag_addr, ag_addr_next;

   assign req_cmd = '{write: bus.req_write, addr: bus.req_addr, len: bus.req_len};

   ram_addr_gen u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ag_load),
      .advance    (ag_advance),
      .start_addr (req_cmd.addr),
      .len        (req_cmd.len),
      .addr       (ag_addr),
      .addr_next  (ag_addr_next),
      .last       (ag_last)
   );

   always_comb begin
      state_d     = state_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      rd_data_d   = rd_data_q;
      wait_d      = wait_q;
      ag_load     = 1'b0;
      ag_advance  = 1'b0;
      unique case (state_q)
         IDLE: if (bus.req_valid) begin
            ag_load = 1'b1;
            if (req_cmd.write) begin
               state_d = WR;
            end else begin
               // Read address is registered on entry so it is already stable throughout RD_ISSUE.
               ram_addr_d = req_cmd.addr;
               state_d    = RD_ISSUE;
            end
         end
         WR: if (bus.wd_valid) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = ag_addr;
            ram_wdata_d = bus.wd_data;
            ag_advance  = 1'b1;
            if (ag_last) state_d = IDLE;
         end
         RD_ISSUE: begin
            wait_d  = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: if (wait_q == WAIT_LAST) begin
            rd_data_d = ram_rdata;
            state_d   = RD_RESP;
         end else begin
            wait_d = wait_q + WCW'(1);
         end
         RD_RESP: if (bus.rd_ready) begin
            if (ag_last) begin
               state_d = IDLE;
            end else begin
               ag_advance = 1'b1;
               ram_addr_d = ag_addr_next;
               state_d    = RD_ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Async reset clears ram_we_q directly, so a reset mid-burst kills the write pulse without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd_data_q   <= '0;
         wait_q      <= '0;
      end else begin
         state_q     <= state_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         rd_data_q   <= rd_data_d;
         wait_q      <= wait_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.wd_ready  = (state_q == WR);
   assign bus.rd_valid  = (state_q == RD_RESP);
   assign bus.rd_data   = rd_data_q;
   assign busy          = (state_q != IDLE);
   assign ram_we        = ram_we_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;

endmodule
